maf_stream_ctrl: RTL

Stream controller that sequences one moving_avg_filter instance (N=16, WIDTH=16) between a valid/ready upstream and a valid/ready downstream. The filter has no backpressure, so this block schedules filter input pulses against a credit count, buffers filter results in a small output FIFO, tracks warm-up, and runs a clean clear/restart sequence. It sits directly around the filter and is the only driver of the filter's clock-enable-like and reset inputs.

---
 rtl/maf_pkg.sv | 21 ++
 rtl/maf_out_fifo.sv | 79 +++++++
 rtl/maf_stream_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/maf_pkg.sv
// -----------------------------------------------------------------------------
// maf_pkg
// Shared definitions for the moving-average stream controller.
//   MAF_WIDTH / MAF_N : default sample width and filter window length
//   MAF_SHIFT         : log2 of the window length (divide-by-N as a shift)
//   state_e           : controller FSM encoding
// -----------------------------------------------------------------------------
package maf_pkg;

  localparam int unsigned MAF_WIDTH = 16;
  localparam int unsigned MAF_N     = 16;
  localparam int unsigned MAF_SHIFT = $clog2(MAF_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

endpackage : maf_pkg

// File: rtl/maf_out_fifo.sv
// -----------------------------------------------------------------------------
// maf_out_fifo
// Synchronous FIFO holding filter results until downstream accepts them.
// Push and pop may occur together, including when full or empty. There is no
// bypass: a push into an empty FIFO becomes visible on the following cycle.
// i_clear empties the FIFO and has priority over push/pop.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : synchronous flush
//   i_push       : write i_push_data (ignored when full unless popping too)
//   i_pop        : remove head entry (ignored when empty)
//   o_head       : head entry, zero when empty
//   o_count      : number of stored entries
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module maf_out_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // written, because o_head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule : maf_out_fifo

// File: rtl/maf_stream_ctrl.sv
// -----------------------------------------------------------------------------
// maf_stream_ctrl
// Sequences a moving-average filter (no backpressure) between a valid/ready
// upstream and a valid/ready downstream. Filter inputs are only issued when a
// FIFO slot is guaranteed for the result (credit scheme), results are queued
// in maf_out_fifo, and a clear request drains the in-flight result, resets the
// filter for one cycle and restarts warm-up.
//   clk, rst_n               : clock, asynchronous active-low reset
//   cfg_enable, cfg_clear    : accept-samples level, clear/restart pulse
//   s_valid/s_ready/s_data   : upstream sample stream
//   m_valid/m_ready/m_data   : downstream average stream
//   f_rst_n, f_in_valid, f_in_sample : drive the filter
//   f_out_valid, f_out_sample        : filter result
//   warm, busy, ovf_err      : window filled, not idle, sticky result drop
// -----------------------------------------------------------------------------
module maf_stream_ctrl
  import maf_pkg::*;
#(
  parameter int unsigned WIDTH      = MAF_WIDTH,
  parameter int unsigned N          = MAF_N,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic             cfg_clear,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             f_rst_n,
  output logic             f_in_valid,
  output logic [WIDTH-1:0] f_in_sample,
  input  logic             f_out_valid,
  input  logic [WIDTH-1:0] f_out_sample,
  output logic             warm,
  output logic             busy,
  output logic             ovf_err
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WCW = $clog2(N) + 1;

  localparam logic [CW-1:0]  DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [WCW-1:0] WARM_FULL   = WCW'(N);
  localparam logic [WCW-1:0] WARM_LAST   = WCW'(N - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic             r_f_rst_n;
  logic             r_inflight;
  logic [WCW-1:0]   r_warm_cnt;
  logic             r_ovf_err;

  logic [CW-1:0]    w_fifo_count;
  logic [CW-1:0]    w_used;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [WIDTH-1:0] w_fifo_head;
  logic             w_pop;
  logic             w_clear;
  logic             w_s_ready;
  logic             w_f_in_valid;

  // Credit: a slot is reserved for every result the filter still owes us.
  assign w_used       = w_fifo_count + CW'(r_inflight);
  assign w_s_ready    = (r_state == ST_RUN) && (w_used < DEPTH_C);
  assign w_f_in_valid = s_valid && w_s_ready;
  assign w_pop        = m_ready && !w_fifo_empty;

  // Flush on the edge entering CLEAR so downstream sees the discard while the
  // filter is held in reset, and keep flushing for the CLEAR cycle itself.
  assign w_clear      = (w_next_state == ST_CLEAR) || (r_state == ST_CLEAR);

  assign s_ready      = w_s_ready;
  assign f_in_valid   = w_f_in_valid;
  assign f_in_sample  = s_data;
  assign f_rst_n      = r_f_rst_n;
  assign m_valid      = !w_fifo_empty;
  assign m_data       = w_fifo_head;
  assign warm         = (r_warm_cnt == WARM_FULL);
  assign busy         = (r_state != ST_IDLE);
  assign ovf_err      = r_ovf_err;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_clear)       w_next_state = ST_DRAIN;
        else if (cfg_enable) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_clear)        w_next_state = ST_DRAIN;
        else if (!cfg_enable) w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        // The filter result lags its input by one cycle; wait for it.
        if (!r_inflight) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_next_state = cfg_enable ? ST_RUN : ST_IDLE;
      end
      default: w_next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_f_rst_n  <= 1'b0;
      r_inflight <= 1'b0;
      r_warm_cnt <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      // Filter reset is low exactly while the FSM sits in CLEAR.
      r_f_rst_n  <= (w_next_state != ST_CLEAR);
      // Warm-up samples produce no result, so they hold no credit.
      r_inflight <= w_f_in_valid && (r_warm_cnt >= WARM_LAST);
      if (w_clear) begin
        r_warm_cnt <= '0;
      end else if (w_f_in_valid && (r_warm_cnt != WARM_FULL)) begin
        r_warm_cnt <= r_warm_cnt + 1'b1;
      end
      if (f_out_valid && w_fifo_full && !w_pop) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  maf_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_push      (f_out_valid),
    .i_push_data (f_out_sample),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

endmodule : maf_stream_ctrl
